// File: rtl/regfile_wb_driver.sv
// Write-back driver for the integer register file: buffers execution-unit results
// in a small FIFO, retires one per cycle, and exposes pending/forward lookups for decode.
module regfile_wb_driver #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  output logic                         wd_en,
  output logic [ADDR_W-1:0]            wd_sel,
  output logic [DATA_W-1:0]            data,
  input  logic [ADDR_W-1:0]            rs1_add,
  input  logic [ADDR_W-1:0]            rs2_add,
  output logic                         rs1_pending,
  output logic                         rs2_pending,
  output logic [DATA_W-1:0]            rs1_fwd,
  output logic [DATA_W-1:0]            rs2_fwd,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  assign wb_ready = (count != CNT_W'(DEPTH));
  // Writes to x0 are acknowledged but never stored.
  assign push     = wb_valid && wb_ready && (wb_addr != '0);
  assign pop      = (count != '0);

  // Stage p0: request FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= wb_addr;
      mem_data[wr_ptr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Stage p1: register-file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_en  <= 1'b0;
      wd_sel <= '0;
      data   <= '0;
    end else if (pop) begin
      wd_en  <= 1'b1;
      wd_sel <= mem_addr[rd_ptr];
      data   <= mem_data[rd_ptr];
    end else begin
      wd_en  <= 1'b0;
    end
  end

  // Newest match wins: output register first, then FIFO head to tail overrides it.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic              hit;
    logic [DATA_W-1:0] val;
    logic [PTR_W-1:0]  idx;
    hit = 1'b0;
    val = '0;
    if (wd_en && (wd_sel == a)) begin
      hit = 1'b1;
      val = data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem_addr[idx] == a)) begin
        hit = 1'b1;
        val = mem_data[idx];
      end
    end
    if (a == '0) begin
      hit = 1'b0;
      val = '0;
    end
    return {hit, val};
  endfunction

  always_comb begin
    {rs1_pending, rs1_fwd} = lookup(rs1_add);
    {rs2_pending, rs2_fwd} = lookup(rs2_add);
  end

endmodule
